// File: rtl/cu_sequencer_if.sv
// Signal bundle between the LEGv8 multi-cycle sequencer and its datapath/control units.
// The sequencer side uses the master modport; the datapath/memory side uses slave.
interface cu_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      IR;
    logic [3:0]       sub_ns;
    logic             mem_access;
    logic             mem_ready;
    logic             halt_req;

    logic [3:0]       state;
    logic [2:0]       cw_sel;
    logic             IR_load;
    logic             PC_en;
    logic             fetch_req;
    logic             retired;
    logic             halted;
    logic             err;
    logic [CNT_W-1:0] instr_count;
    logic [1:0]       top_state;

    // A memory access is requested by fetch_req (FETCH) or mem_access (EXEC) and
    // completes on the first cycle where the request and mem_ready are both high;
    // until then the request stays asserted and the sequencer holds its state.
    modport master (
        input  IR, sub_ns, mem_access, mem_ready, halt_req,
        output state, cw_sel, IR_load, PC_en, fetch_req, retired, halted, err,
               instr_count, top_state
    );

    modport slave (
        output IR, sub_ns, mem_access, mem_ready, halt_req,
        input  state, cw_sel, IR_load, PC_en, fetch_req, retired, halted, err,
               instr_count, top_state
    );
endinterface

// File: rtl/cu_sequencer.sv
// LEGv8 multi-cycle sequencer: FETCH -> DECODE -> EXEC per instruction, with stalls,
// retire counting and sticky halt/error. Define CU_SEQ_WATCHDOG_EN for the memory-wait watchdog.
module cu_sequencer #(
    parameter int CNT_W      = 16,
    parameter int MAX_EXEC   = 8,
    parameter int WDOG_LIMIT = 64
) (
    input  logic            clock,
    input  logic            reset,
    cu_sequencer_if.master  bus
);
    typedef enum logic [1:0] {
        TOP_FETCH  = 2'd0,
        TOP_DECODE = 2'd1,
        TOP_EXEC   = 2'd2,
        TOP_HALT   = 2'd3
    } top_t;

    localparam logic [2:0] CW_R     = 3'd0;
    localparam logic [2:0] CW_I     = 3'd1;
    localparam logic [2:0] CW_D     = 3'd2;
    localparam logic [2:0] CW_B     = 3'd3;
    localparam logic [2:0] CW_CB    = 3'd4;
    localparam logic [2:0] CW_BCOND = 3'd5;
    localparam logic [2:0] CW_FETCH = 3'd6;
    localparam logic [2:0] CW_IDLE  = 3'd7;

    localparam int EXW = $clog2(MAX_EXEC + 1);

    top_t             top_q, top_d;
    logic [3:0]       sub_q, sub_d;
    logic [EXW-1:0]   exec_cnt_q, exec_cnt_d;
    logic [2:0]       cls_q, cls_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             halted_q, halted_d;
    logic             err_q, err_d;

    logic [2:0]       cls_dec;
    logic             exec_stall;
    logic             retire_now;
    logic             fetch_done;
    logic             err_set;

    logic [2:0]       cw_sel;
    logic             fetch_req;
    logic             ir_load;
    logic             pc_en;
    logic             retired;

`ifdef CU_SEQ_WATCHDOG_EN
    localparam int WDW = $clog2(WDOG_LIMIT + 1);
    logic [WDW-1:0] wd_q, wd_d;
    logic           mem_wait;
`else
    localparam int unused_wdog_limit = WDOG_LIMIT;
`endif

    // Only the opcode field IR[31:21] takes part in classification.
    logic unused_ir;
    assign unused_ir = ^bus.IR[20:0];

    always_comb begin
        if (bus.IR[31:24] == 8'hF8 && !bus.IR[21])                  cls_dec = CW_D;
        else if (bus.IR[31:26] == 6'b000101)                        cls_dec = CW_B;
        else if (bus.IR[31:25] == 7'b1011010)                       cls_dec = CW_CB;
        else if (bus.IR[31:24] == 8'h54)                            cls_dec = CW_BCOND;
        else if (bus.IR[28:25] == 4'b0101 && bus.IR[23:21] == 3'b000) cls_dec = CW_R;
        else if (bus.IR[28:26] == 3'b100)                           cls_dec = CW_I;
        else                                                        cls_dec = CW_IDLE;
    end

    assign exec_stall = (top_q == TOP_EXEC) && bus.mem_access && !bus.mem_ready;
    assign retire_now = (top_q == TOP_EXEC) && !exec_stall && (bus.sub_ns == 4'd0);
    assign fetch_done = (top_q == TOP_FETCH) && !bus.halt_req && bus.mem_ready;

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            top_q      <= TOP_FETCH;
            sub_q      <= 4'd0;
            exec_cnt_q <= '0;
            cls_q      <= CW_IDLE;
            cnt_q      <= '0;
            halted_q   <= 1'b0;
            err_q      <= 1'b0;
`ifdef CU_SEQ_WATCHDOG_EN
            wd_q       <= '0;
`endif
        end else begin
            top_q      <= top_d;
            sub_q      <= sub_d;
            exec_cnt_q <= exec_cnt_d;
            cls_q      <= cls_d;
            cnt_q      <= cnt_d;
            halted_q   <= halted_d;
            err_q      <= err_d;
`ifdef CU_SEQ_WATCHDOG_EN
            wd_q       <= wd_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        top_d      = top_q;
        sub_d      = sub_q;
        exec_cnt_d = exec_cnt_q;
        cls_d      = cls_q;
        cnt_d      = cnt_q;
        err_set    = 1'b0;

        case (top_q)
            TOP_FETCH: begin
                if (bus.halt_req)       top_d = TOP_HALT;
                else if (bus.mem_ready) top_d = TOP_DECODE;
            end
            TOP_DECODE: begin
                cls_d      = cls_dec;
                sub_d      = 4'd0;
                exec_cnt_d = '0;
                if (cls_dec == CW_IDLE) begin
                    top_d   = TOP_HALT;
                    err_set = 1'b1;
                end else begin
                    top_d = TOP_EXEC;
                end
            end
            TOP_EXEC: begin
                if (!exec_stall) begin
                    if (bus.sub_ns == 4'd0) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        sub_d = 4'd0;
                        top_d = bus.halt_req ? TOP_HALT : TOP_FETCH;
                    end else begin
                        sub_d      = bus.sub_ns;
                        exec_cnt_d = exec_cnt_q + EXW'(1);
                        // The MAX_EXEC-th non-retiring step is an overrun.
                        if (exec_cnt_q == EXW'(MAX_EXEC - 1)) begin
                            top_d   = TOP_HALT;
                            err_set = 1'b1;
                        end
                    end
                end
            end
            default: begin
            end
        endcase

`ifdef CU_SEQ_WATCHDOG_EN
        mem_wait = ((top_q == TOP_FETCH) && !bus.halt_req && !bus.mem_ready) || exec_stall;
        wd_d     = '0;
        if (mem_wait && (top_d == top_q)) begin
            wd_d = wd_q + WDW'(1);
            if (wd_d == WDW'(WDOG_LIMIT)) begin
                top_d   = TOP_HALT;
                err_set = 1'b1;
            end
        end
`endif

        halted_d = halted_q | (top_d == TOP_HALT);
        err_d    = err_q | err_set;
    end

    // Output logic; the Mealy pulses are held low while reset is asserted.
    always_comb begin
        cw_sel    = CW_IDLE;
        fetch_req = 1'b0;
        ir_load   = 1'b0;
        pc_en     = 1'b0;
        retired   = 1'b0;
        case (top_q)
            TOP_FETCH: begin
                cw_sel    = CW_FETCH;
                fetch_req = 1'b1;
                ir_load   = reset && fetch_done;
                pc_en     = reset && fetch_done;
            end
            TOP_EXEC: begin
                cw_sel  = cls_q;
                retired = reset && retire_now;
            end
            default: begin
                cw_sel = CW_IDLE;
            end
        endcase
    end

    assign bus.state       = sub_q;
    assign bus.cw_sel      = cw_sel;
    assign bus.IR_load     = ir_load;
    assign bus.PC_en       = pc_en;
    assign bus.fetch_req   = fetch_req;
    assign bus.retired     = retired;
    assign bus.halted      = halted_q;
    assign bus.err         = err_q;
    assign bus.instr_count = cnt_q;
    assign bus.top_state   = top_q;
endmodule
